// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request port.
// One request is held at a time. After acceptance the block waits LATENCY
// cycles, performs the access and emits a single-cycle response.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE while start is high. There is no response
// backpressure. resp_valid is a one-cycle pulse in RESP, and resp_rdata/resp_err
// are meaningful only in that cycle. All three are zero otherwise.
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               start,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_be,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_err,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int NB = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;
    localparam logic [CW-1:0]    LAT_INIT   = CW'(LATENCY);
    localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(DEPTH * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // FSM state and wait counter
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Latched request
    logic             write_q, write_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]    be_q, be_d;

    // Registered response
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    // Storage (not reset)
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             addr_err;
    logic             fire;
    logic             mem_we;
    logic [AW-1:0]    word_idx;
    logic [WIDTH-1:0] mem_rd_word;

    // Request port status, derived from state only (plus reset)
    always_comb begin
        req_ready = (state_q == ST_IDLE) && start;
        busy      = (state_q != ST_IDLE);
        dbg_state = state_q;
    end

    // Decode of the held request; the access happens on the last WAIT cycle
    always_comb begin
        accept      = req_valid && req_ready;
        addr_err    = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
        word_idx    = addr_q[AW+1:2];
        fire        = (state_q == ST_WAIT) && (cnt_q == '0);
        mem_we      = fire && write_q && !addr_err;
        mem_rd_word = mem[word_idx];
    end

    // Next-state logic; response fields default to zero outside RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = addr_err;
                    if (!write_q && !addr_err) begin
                        resp_rdata_d = mem_rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, request latch and registered response; reset discards any held request
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-masked store; mem_we is low whenever reset holds the FSM in IDLE
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Drive response ports from their registers
    always_comb begin
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hand-written multi-cycle corner
// cases, randomized traffic against a word-array model, and a LATENCY=0 build.
module tb_dmem_responder;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic start;

    // Main instance (LATENCY=2)
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    // Zero-latency instance
    logic        z_valid, z_ready, z_write;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_be;
    logic        z_rvalid, z_err, z_busy;
    logic [31:0] z_rdata;
    logic [1:0]  z_dbg;

    dmem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    dmem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH0), .LATENCY(0)) u_dut0 (
        .clk(clk), .start(start),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
        .resp_valid(z_rvalid), .resp_rdata(z_rdata), .resp_err(z_err),
        .busy(z_busy), .dbg_state(z_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain word array, updated by the addressing rules
    logic [31:0] mem_m [DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int idx;
        idx = int'(a / 4);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Driver + scoreboard for one transaction on the main instance
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input string name,
                          output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          k;
        bit          seen;
        exp_e = model_err(a);
        exp_d = 32'h0;
        if (!w && !exp_e) exp_d = mem_m[int'(a / 4)];
        if (w && !exp_e) model_store(a, d, be);
        got_d = 32'hx;
        got_e = 1'bx;

        req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin tick; k++; end
        check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        tick;                                   // acceptance edge
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        k = 0; seen = 0;
        while (k < 40 && !seen) begin
            if (resp_valid) seen = 1;
            else begin tick; k++; end
        end
        check({name, "_resp_seen"}, {31'b0, seen}, 32'd1);
        if (!seen) return;
        check({name, "_latency"}, 32'(k), 32'(LAT + 1));
        got_d = resp_rdata;
        got_e = resp_err;
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, exp_e});
        check({name, "_rdata"}, resp_rdata, exp_d);
        tick;
        check({name, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
        check({name, "_idle_rdata"}, resp_rdata, 32'd0);
        check({name, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Transaction on the zero-latency instance
    task automatic z_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                         input string name);
        z_write = w; z_addr = a; z_wdata = d; z_be = be; z_valid = 1'b1;
        check({name, "_ready"}, {31'b0, z_ready}, 32'd1);
        tick;
        z_valid = 1'b0;
        check({name, "_wait"}, {31'b0, z_rvalid}, 32'd0);
        tick;
        check({name, "_valid"}, {31'b0, z_rvalid}, 32'd1);
        check({name, "_err"}, {31'b0, z_err}, {31'b0, exp_e});
        check({name, "_rdata"}, z_rdata, exp_d);
        tick;
        check({name, "_end"}, {31'b0, z_rvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] gd;
        logic        ge;
        int          acc [$];
        int          k;
        bit          any;
        logic [31:0] a;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        tbl[4]  = '{1'b1, 32'h10,  32'h12345678, 4'h0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        tbl[6]  = '{1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 32'h0,   32'h01234567, 4'hF, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h01234567, 1'b0};
        tbl[10] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 32'h3FC, 32'h0000FF00, 4'h2, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5FFA5, 1'b0};
        tbl[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'h3FE, 32'h0,        4'h0, 32'h0,        1'b1};

        // Reset
        start = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
        req_valid = 1'b1;
        tick; tick;
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        tick;
        req_valid = 1'b0;
        start = 1'b1;
        tick;

        // Fill every word so no load returns X
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, "init", gd, ge);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, $sformatf("tbl%0d", i), gd, ge);
            check($sformatf("tbl%0d_exp_rdata", i), gd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_exp_err", i), {31'b0, ge}, {31'b0, tbl[i].exp_err});
        end

        // Held req_valid: ready low while busy, acceptances every LAT+3 cycles
        req_write = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = '0; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bit rdy;
            rdy = req_ready;
            check("hold_ready_vs_busy", {31'b0, req_ready}, {31'b0, ~busy});
            tick;
            if (rdy) acc.push_back(c);
            if (resp_valid) check("hold_rdata", resp_rdata, mem_m[4]);
        end
        req_valid = 1'b0;
        check("hold_accept_count", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++)
            check("hold_accept_gap", 32'(acc[i] - acc[i-1]), 32'(LAT + 3));
        k = 0;
        while (busy && k < 20) begin tick; k++; end

        // Reset while in WAIT: store discarded, no response
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        check("rstwait_busy_before", {31'b0, busy}, 32'd1);
        start = 1'b0;
        #1;
        check("rstwait_busy", {31'b0, busy}, 32'd0);
        check("rstwait_ready", {31'b0, req_ready}, 32'd0);
        check("rstwait_resp", {31'b0, resp_valid}, 32'd0);
        tick; tick;
        start = 1'b1;
        tick;
        check("rstwait_ready_after", {31'b0, req_ready}, 32'd1);
        any = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) any = 1;
            tick;
        end
        check("rstwait_no_resp", {31'b0, any}, 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, "rstwait_load", gd, ge);

        // Reset while in RESP: store already committed, pulse cut
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h0BADF00D; req_be = 4'hF; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin tick; k++; end
        check("rstresp_seen", {31'b0, resp_valid}, 32'd1);
        start = 1'b0;
        #1;
        check("rstresp_cut", {31'b0, resp_valid}, 32'd0);
        check("rstresp_busy", {31'b0, busy}, 32'd0);
        tick;
        start = 1'b1;
        tick;
        model_store(32'h24, 32'h0BADF00D, 4'hF);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, "rstresp_load", gd, ge);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'($urandom_range(0, 1023)) | 32'd1;
            else if (sel == 1) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 4095)) << 2);
            else               a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand", gd, ge);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick;
        end

        // Zero-latency build
        z_req(1'b1, 32'h8,  32'h5A5A1234, 4'hF, 32'h0,        1'b0, "lat0_store");
        z_req(1'b0, 32'h8,  32'h0,        4'h0, 32'h5A5A1234, 1'b0, "lat0_load");
        z_req(1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1, "lat0_range");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
